// File: rtl/clint_regs.sv
// CLINT register back-end: mtime counter, per-hart mtimecmp/msip, timer and software interrupts.
// Build option CLINT_RTC_SYNC_EN adds a 2-flop synchronizer in front of the rtc edge detector.
module clint_regs #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned NR_CORES       = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [AXI_ADDR_WIDTH-1:0] address_i,
    input  logic                      en_i,
    input  logic                      we_i,
    input  logic [AXI_DATA_WIDTH-1:0] data_i,
    output logic [AXI_DATA_WIDTH-1:0] data_o,
    input  logic                      rtc_i,
    output logic [NR_CORES-1:0]       timer_irq_o,
    output logic [NR_CORES-1:0]       ipi_o
);

    // Decode works on 64-bit word indices (address_i[15:3]).
    localparam logic [12:0] MSIP_BASE     = 13'h0000;
    localparam logic [12:0] MTIMECMP_BASE = 13'h0800;
    localparam logic [12:0] MTIME_WORD    = 13'h17FF;

    logic [12:0] word;
    logic        wr_en;
    logic [63:0] wdata;
    logic        unused_addr;

    assign word  = address_i[15:3];
    assign wr_en = en_i & we_i;
    assign wdata = data_i[63:0];

    // The map aliases: upper address bits and the byte offset take no part in decode.
    if (AXI_ADDR_WIDTH > 16) begin : g_addr_wide
        assign unused_addr = ^{address_i[AXI_ADDR_WIDTH-1:16], address_i[2:0]};
    end else begin : g_addr_narrow
        assign unused_addr = ^address_i[2:0];
    end

    // ------------------------------------------------------------------
    // rtc conditioning and edge detect
    // ------------------------------------------------------------------
    logic rtc_cond;
    logic rtc_q;
    logic rtc_tick;

`ifdef CLINT_RTC_SYNC_EN
    logic [1:0] rtc_sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rtc_sync_q <= '0;
        end else begin
            rtc_sync_q <= {rtc_sync_q[0], rtc_i};
        end
    end

    assign rtc_cond = rtc_sync_q[1];
`else
    assign rtc_cond = rtc_i;
`endif

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rtc_q <= 1'b0;
        end else begin
            rtc_q <= rtc_cond;
        end
    end

    assign rtc_tick = rtc_cond & ~rtc_q;

    // ------------------------------------------------------------------
    // mtime: a software write takes priority over a coincident tick
    // ------------------------------------------------------------------
    logic [63:0] mtime_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime_q <= '0;
        end else if (wr_en && word == MTIME_WORD) begin
            mtime_q <= wdata;
        end else if (rtc_tick) begin
            mtime_q <= mtime_q + 64'd1;
        end
    end

    // ------------------------------------------------------------------
    // Per-hart msip, mtimecmp and registered timer compare
    // ------------------------------------------------------------------
    logic [63:0]         mtimecmp_q [NR_CORES];
    logic [NR_CORES-1:0] msip_q;
    logic [NR_CORES-1:0] timer_irq_q;

    // NOTE: mtimecmp is a small register array, not a RAM; it must come out of reset as all-ones
    // so no hart sees a spurious timer interrupt, hence every entry is reset explicitly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            msip_q      <= '0;
            timer_irq_q <= '0;
            for (int h = 0; h < NR_CORES; h++) begin
                mtimecmp_q[h] <= '1;
            end
        end else begin
            for (int h = 0; h < NR_CORES; h++) begin
                timer_irq_q[h] <= (mtime_q >= mtimecmp_q[h]);
                if (wr_en && word == MSIP_BASE + 13'(h)) begin
                    msip_q[h] <= wdata[0];
                end
                if (wr_en && word == MTIMECMP_BASE + 13'(h)) begin
                    mtimecmp_q[h] <= wdata;
                end
            end
        end
    end

    assign timer_irq_o = timer_irq_q;
    assign ipi_o       = msip_q;

    // ------------------------------------------------------------------
    // Zero-latency read mux; unmapped offsets read as zero
    // ------------------------------------------------------------------
    logic [63:0] rdata;

    // NOTE: rdata gets a default before any decode so the mux never infers a latch.
    always_comb begin
        rdata = '0;
        if (word == MTIME_WORD) begin
            rdata = mtime_q;
        end
        for (int h = 0; h < NR_CORES; h++) begin
            if (word == MSIP_BASE + 13'(h)) begin
                rdata = {63'b0, msip_q[h]};
            end
            if (word == MTIMECMP_BASE + 13'(h)) begin
                rdata = mtimecmp_q[h];
            end
        end
    end

    assign data_o = rdata;

endmodule

// File: tb/tb_clint_regs.sv
// Self-checking bench for clint_regs (two harts): directed steps plus random traffic
// compared against a register-level reference model.
module tb_clint_regs;

    localparam int NR = 2;
`ifdef CLINT_RTC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [63:0]   address_i = '0;
    logic          en_i = 1'b0;
    logic          we_i = 1'b0;
    logic [63:0]   data_i = '0;
    logic [63:0]   data_o;
    logic          rtc_i = 1'b0;
    logic [NR-1:0] timer_irq_o;
    logic [NR-1:0] ipi_o;

    int n_assert = 0;
    int n_fail   = 0;

    clint_regs #(
        .AXI_ADDR_WIDTH(64),
        .AXI_DATA_WIDTH(64),
        .NR_CORES      (NR)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .address_i  (address_i),
        .en_i       (en_i),
        .we_i       (we_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .rtc_i      (rtc_i),
        .timer_irq_o(timer_irq_o),
        .ipi_o      (ipi_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    logic [63:0]   m_mtime;
    logic [63:0]   m_cmp [NR];
    logic [NR-1:0] m_msip;
    logic [NR-1:0] m_irq;
    logic [3:0]    m_hist;
    logic [3:0]    rtc_seen;

    // rtc_seen[j] is the rtc level sampled j edges ago (j = 0 is this edge).
    assign rtc_seen = {m_hist[2:0], rtc_i};

    function automatic int byte_off(input logic [63:0] a);
        return int'(a[15:0]) & ~7;
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] a);
        int off;
        off = byte_off(a);
        if (off == 'hBFF8) return m_mtime;
        if (off < 8 * NR) return {63'b0, m_msip[off / 8]};
        if (off >= 'h4000 && off < 'h4000 + 8 * NR) return m_cmp[(off - 'h4000) / 8];
        return 64'd0;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_mtime <= '0;
            m_msip  <= '0;
            m_irq   <= '0;
            m_hist  <= '0;
            for (int h = 0; h < NR; h++) m_cmp[h] <= '1;
        end else begin
            m_hist <= rtc_seen;
            for (int h = 0; h < NR; h++) m_irq[h] <= (m_mtime >= m_cmp[h]);
            if (rtc_seen[LAT] && !rtc_seen[LAT+1]) m_mtime <= m_mtime + 64'd1;
            if (en_i && we_i) begin
                if (byte_off(address_i) == 'hBFF8)
                    m_mtime <= data_i;
                else if (byte_off(address_i) < 8 * NR)
                    m_msip[byte_off(address_i) / 8] <= data_i[0];
                else if (byte_off(address_i) >= 'h4000 && byte_off(address_i) < 'h4000 + 8 * NR)
                    m_cmp[(byte_off(address_i) - 'h4000) / 8] <= data_i;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic check_lines(input string tag);
        check({tag, "_irq"}, 64'(timer_irq_o), 64'(m_irq));
        check({tag, "_ipi"}, 64'(ipi_o), 64'(m_msip));
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        address_i = a; data_i = d; en_i = 1'b1; we_i = 1'b1;
        @(negedge clk_i);
        en_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [63:0] a, input logic [63:0] exp);
        address_i = a; en_i = 1'b1; we_i = 1'b0;
        #1;
        check(tag, data_o, exp);
        en_i = 1'b0;
    endtask

    task automatic idle_chk(input int n, input string tag);
        repeat (n) begin
            @(negedge clk_i);
            check_lines(tag);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Reset values
        rd("rst_mtime", 64'hBFF8, 64'd0);
        rd("rst_cmp0", 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF);
        rd("rst_msip0", 64'h0000, 64'd0);
        check("rst_irq", 64'(timer_irq_o), 64'd0);
        check("rst_ipi", 64'(ipi_o), 64'd0);
        @(negedge clk_i);

        // Timer interrupt from two rtc ticks
        wr(64'hBFF8, 64'h10);
        wr(64'h4000, 64'h12);
        repeat (2) begin
            rtc_i = 1'b1;
            idle_chk(3, "tmr");
            rtc_i = 1'b0;
            idle_chk(3, "tmr");
        end
        idle_chk(LAT, "tmr");
        rd("tmr_mtime", 64'hBFF8, 64'h12);
        check("tmr_irq_high", 64'(timer_irq_o[0]), 64'd1);
        @(negedge clk_i);
        wr(64'h4000, 64'h100);
        check("tmr_irq_hold", 64'(timer_irq_o[0]), 64'd1);
        @(negedge clk_i);
        check("tmr_irq_drop", 64'(timer_irq_o[0]), 64'd0);

        // Software interrupt
        wr(64'h0000, 64'h3);
        check("sw_ipi_set", 64'(ipi_o[0]), 64'd1);
        rd("sw_read", 64'h0000, 64'h1);
        @(negedge clk_i);
        wr(64'h0000, 64'h0);
        check("sw_ipi_clr", 64'(ipi_o[0]), 64'd0);

        // Tick and write of mtime in the same cycle: write wins
        rtc_i = 1'b1;
        repeat (LAT) @(negedge clk_i);
        wr(64'hBFF8, 64'h5);
        rd("coll_mtime", 64'hBFF8, 64'h5);
        rtc_i = 1'b0;
        idle_chk(LAT + 2, "coll");
        rd("coll_mtime_later", 64'hBFF8, 64'h5);
        @(negedge clk_i);

        // Wrap to zero drops the interrupt
        wr(64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(64'h4000, 64'h1);
        idle_chk(2, "wrap");
        check("wrap_irq_high", 64'(timer_irq_o[0]), 64'd1);
        rtc_i = 1'b1;
        @(negedge clk_i);
        rtc_i = 1'b0;
        idle_chk(LAT + 2, "wrap");
        rd("wrap_mtime", 64'hBFF8, 64'd0);
        check("wrap_irq_low", 64'(timer_irq_o[0]), 64'd0);
        @(negedge clk_i);

        // Unmapped offsets, missing hart 2, second hart independence, aliasing
        wr(64'h4008, 64'hAAAA_5555_0000_1234);
        wr(64'h4010, 64'h1234);
        wr(64'h8000, 64'h5678);
        wr(64'h0010, 64'h1);
        rd("unm_4010", 64'h4010, 64'd0);
        rd("unm_8000", 64'h8000, 64'd0);
        rd("unm_0010", 64'h0010, 64'd0);
        @(negedge clk_i);
        rd("hart1_cmp", 64'h4008, 64'hAAAA_5555_0000_1234);
        rd("hart0_cmp", 64'h4000, 64'h1);
        check("unm_ipi", 64'(ipi_o), 64'd0);
        @(negedge clk_i);
        rd("alias_hi", 64'h0001_0000_0000_BFF8, model_read(64'hBFF8));
        rd("alias_lo", 64'h400F, 64'hAAAA_5555_0000_1234);
        @(negedge clk_i);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [63:0] pool [10];
            pool = '{64'h0, 64'h8, 64'h10, 64'h4000, 64'h4008, 64'h4010,
                     64'hBFF8, 64'h8000, 64'h0003_0000_4004, 64'h0000_0010_BFFC};
            @(negedge clk_i);
            check("rnd_rdata", data_o, model_read(address_i));
            check_lines("rnd");
            address_i = pool[$urandom_range(0, 9)];
            en_i = 1'($urandom_range(0, 1));
            we_i = 1'($urandom_range(0, 1));
            data_i = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                 : 64'($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0) rtc_i = ~rtc_i;
        end
        @(negedge clk_i);
        en_i = 1'b0; we_i = 1'b0; rtc_i = 1'b0;

        // Asynchronous reset mid-operation
        wr(64'h0000, 64'h1);
        wr(64'h4000, 64'h0);
        idle_chk(2, "pre_rst");
        check("pre_rst_irq", 64'(timer_irq_o[0]), 64'd1);
        check("pre_rst_ipi", 64'(ipi_o[0]), 64'd1);
        address_i = 64'hBFF8;
        #2 rst_i = 1'b1;
        #1;
        check("arst_irq", 64'(timer_irq_o), 64'd0);
        check("arst_ipi", 64'(ipi_o), 64'd0);
        check("arst_mtime", data_o, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        rd("arst_cmp0", 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
